// File: rtl/delayer_pkg.sv
// rtl/delayer_pkg.sv - shared default parameters for the delayer line
package delayer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DELAY = 5;

endpackage

// File: rtl/delayer_stage.sv
// rtl/delayer_stage.sv - one WIDTH-bit register of the delay chain
// Asynchronous active-low clear, loads only while enabled.
module delayer_stage
  import delayer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/delayer.sv
// rtl/delayer.sv - stallable fixed-latency delay line of DELAY register stages
// DELAY=0 collapses to a plain wire from in to out.
module delayer
  import delayer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DELAY = DEFAULT_DELAY
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  generate
    if (DELAY == 0) begin : g_pass
      // Clock, reset and stall are intentionally unused in the passthrough build.
      logic w_unused;
      assign w_unused = ^{clk, rstn, stall};
      assign out      = in;
    end else begin : g_chain
      logic [WIDTH-1:0] w_chain [DELAY+1];
      logic             w_en;

      assign w_en       = !stall;
      assign w_chain[0] = in;

      for (genvar i = 0; i < DELAY; i++) begin : g_stage
        delayer_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk  (clk),
          .rstn (rstn),
          .i_en (w_en),
          .i_d  (w_chain[i]),
          .o_q  (w_chain[i+1])
        );
      end

      assign out = w_chain[DELAY];
    end
  endgenerate

endmodule

// File: tb/tb_delayer.sv
// tb/tb_delayer.sv - self-checking bench for delayer with DELAY 5, 1 and 0
module tb_delayer;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic [31:0] in;
  logic [31:0] out5;
  logic [31:0] out1;
  logic [31:0] out0;

  int          errors;
  int          checks;
  int          n_edges;
  logic [31:0] hist[$];
  logic [31:0] held;

  delayer #(.WIDTH(32), .DELAY(5)) u_d5 (
    .clk   (clk),
    .rstn  (rstn),
    .stall (stall),
    .in    (in),
    .out   (out5)
  );

  delayer #(.WIDTH(32), .DELAY(1)) u_d1 (
    .clk   (clk),
    .rstn  (rstn),
    .stall (stall),
    .in    (in),
    .out   (out1)
  );

  delayer #(.WIDTH(32), .DELAY(0)) u_d0 (
    .clk   (clk),
    .rstn  (rstn),
    .stall (stall),
    .in    (in),
    .out   (out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output of a DELAY-d line: the word taken d unstalled edges ago, or 0 before that.
  function automatic logic [31:0] expect_out(input int d);
    if (n_edges >= d) return hist[n_edges - d];
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic [31:0] d);
    stall = s;
    in    = d;
    #1;
    check("d0_comb", out0, d);
    @(posedge clk);
    if (rstn && !s) begin
      hist.push_back(d);
      n_edges++;
    end
    #1;
    check("d5_model", out5, expect_out(5));
    check("d1_model", out1, expect_out(1));
    check("d0_after_edge", out0, d);
  endtask

  task automatic clear_model();
    hist.delete();
    n_edges = 0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    n_edges = 0;
    rstn    = 1'b0;
    stall   = 1'b0;
    in      = 32'hDEADBEEF;

    #1;
    check("reset_d5", out5, 32'h0);
    check("reset_d1", out1, 32'h0);
    check("reset_d0", out0, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) step(1'b0, 32'hDEADBEEF);
    #3;
    check("reset_mid_d5", out5, 32'h0);
    rstn = 1'b1;

    // Fill with an incrementing sequence: first word appears after the 5th edge.
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 32'(i));
      check("fill_d5", out5, (i >= 5) ? 32'(i - 4) : 32'h0);
      check("fill_d1", out1, 32'(i));
    end

    held = out5;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom);
      check("stall_hold", out5, held);
    end
    for (int i = 13; i <= 16; i++) begin
      step(1'b0, 32'(i));
      check("stall_resume", out5, 32'(i - 4));
    end

    step(1'b1, 32'hBAD0BAD0);
    check("pulse_hold", out5, 32'(12));
    for (int i = 17; i <= 20; i++) begin
      step(1'b0, 32'(i));
      check("pulse_resume", out5, 32'(i - 4));
    end

    #2;
    rstn = 1'b0;
    #1;
    check("midreset_d5", out5, 32'h0);
    check("midreset_d1", out1, 32'h0);
    clear_model();
    step(1'b0, 32'h12345678);
    step(1'b1, 32'h9ABCDEF0);
    #2;
    rstn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 32'(100 + i));
      check("refill_d5", out5, (i >= 5) ? 32'(100 + i - 4) : 32'h0);
    end

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 3) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delayer.md
# delayer

Parameterised, stallable fixed-latency delay line: a word presented on `in` reappears on `out` after exactly DELAY unstalled clock edges. It sits in the accelerator datapath to align sideband data or operands with a pipeline of known depth. While `stall` is high, the whole line freezes, so alignment is preserved across pipeline bubbles.

## Interface
- WIDTH, default 32: data word width in bits (≥1).
- DELAY, default 5: number of register stages / edges of latency (≥0).

- clk  input  1  rising-edge clock.
- rstn  input  1  reset; one clock; reset is asynchronous and active-low.
- stall  input  1  synchronous freeze; 1 = hold every stage.
- in  input  WIDTH  data word to delay.
- out  output  WIDTH  data word delayed by DELAY unstalled edges.

## Operation
- DELAY ≥ 1: chain of DELAY registers, stage[0..DELAY-1], each WIDTH bits.
- On a rising edge with rstn=1 and stall=0: stage[0] <= in; stage[i] <= stage[i-1] for i = 1..DELAY-1.
- On a rising edge with stall=1: every stage holds its value; `in` is not sampled (a word present only during stalled edges is dropped).
- out = stage[DELAY-1], driven directly from a register (no combinational path from in or stall).
- DELAY = 0: no registers; out = in combinationally; stall and rstn have no effect.
- No arithmetic; data is passed bit-exact, no width changes.

## Timing
- Reset: rstn low asynchronously clears every stage to 0, so out = 0 immediately and throughout reset. Reset dominates stall.
- After reset release, out stays 0 until DELAY unstalled edges have occurred. Edges at which rstn is low do not count.
- Latency: the word sampled at unstalled edge e is on out right after the DELAY-th unstalled edge counted from e inclusive. For DELAY=5, a word sampled at edge 1 appears after edge 5.
- Stall for N edges: out holds constant for those N edges, and the total latency of every in-flight word grows by N.
- Stall asserted and deasserted on consecutive edges: only the stalled edge is frozen. No glitch or skipped word on out.
- Reset mid-operation: all in-flight words are discarded and the line refills from 0 as after power-up.

## Structure
- No shared package is required. WIDTH and DELAY are module parameters only.
- One natural sub-module: `delayer_stage`, a single WIDTH-bit register with async active-low clear and enable (enable = !stall).
- Generate DELAY instances of `delayer_stage` in a chain. Use a generate branch for DELAY=0 passthrough.

## Test plan
- Reset check, WIDTH=32, DELAY=5: hold rstn=0 with in=0xDEADBEEF -> out=0 throughout reset, including asynchronously mid-cycle.
- Fill and latency: release reset and set in = 1,2,3,... incrementing on every edge with stall=0 -> out=0 for the first 4 edges, out=1 after the 5th edge, then out increments by 1 every edge.
- Stall: after steady state, hold stall=1 for 3 edges -> out frozen at its current value for 3 edges; input words offered during the stall never appear; the sequence resumes in order on the first unstalled edge.
- Single-cycle stall pulse -> exactly one repeated out value, no other disturbance.
- Mid-stream reset: pulse rstn low between edges while out≠0 -> out=0 immediately; after release, 5 unstalled edges elapse before new data appears.
- DELAY=0 and DELAY=1 builds: DELAY=0 gives out tracking in combinationally; DELAY=1 gives out = in from the previous unstalled edge.
